// File: rtl/uart_resp_tx.sv
// Buffered 8N1 UART transmitter for the BNN response path: a small byte FIFO
// feeds an LSB-first serialiser whose frame starts are gated by the host RTS.
module uart_resp_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic       UART_RTS,
    output logic       UART_Tx,
    output logic       busy,
    output logic       fifo_empty,
    output logic       fifo_full
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [BW-1:0] BAUD_ZERO = BW'(0);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          empty_r;
    logic          full_r;
    logic          ready_r;
    logic          push_s;
    logic          pop_s;
    logic [7:0]    head_s;

    logic          rts_meta_r;
    logic          rts_sync_r;

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [BW-1:0] baud_r;
    logic [BW-1:0] baud_nxt_s;
    logic [2:0]    bit_idx_r;
    logic [2:0]    bit_idx_nxt_s;
    logic [7:0]    shreg_r;
    logic [7:0]    shreg_nxt_s;
    logic          tx_r;
    logic          tx_nxt_s;
    logic          busy_r;
    logic          busy_nxt_s;
    logic          bit_end_s;
    logic          start_ok_s;

    assign push_s     = data_valid && ready_r;
    assign head_s     = mem_r[rd_ptr_r];
    assign bit_end_s  = (baud_r == BAUD_LAST);
    assign start_ok_s = !empty_r && rts_sync_r;

    // Occupancy after this edge; flags are registered from it so they track count_r exactly.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // FIFO pointers, count and registered status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= CNT_ZERO;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            ready_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == CNT_ZERO);
            full_r  <= (count_nxt_s == CNT_FULL);
            ready_r <= (count_nxt_s != CNT_FULL);
        end
    end

    // Byte storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Two-flop synchroniser for the asynchronous host RTS line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rts_meta_r <= 1'b0;
            rts_sync_r <= 1'b0;
        end else begin
            rts_meta_r <= UART_RTS;
            rts_sync_r <= rts_meta_r;
        end
    end

    // Frame sequencer; the line level is computed one cycle ahead so UART_Tx is a flop.
    always_comb begin
        state_nxt_s   = state_r;
        baud_nxt_s    = baud_r;
        bit_idx_nxt_s = bit_idx_r;
        shreg_nxt_s   = shreg_r;
        tx_nxt_s      = tx_r;
        busy_nxt_s    = busy_r;
        pop_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    pop_s       = 1'b1;
                    shreg_nxt_s = head_s;
                    baud_nxt_s  = BAUD_ZERO;
                    state_nxt_s = ST_START;
                    tx_nxt_s    = 1'b0;
                    busy_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    tx_nxt_s    = 1'b1;
                    busy_nxt_s  = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    baud_nxt_s    = BAUD_ZERO;
                    bit_idx_nxt_s = 3'd0;
                    state_nxt_s   = ST_DATA;
                    tx_nxt_s      = shreg_r[0];
                end else begin
                    baud_nxt_s = baud_r + BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    baud_nxt_s = BAUD_ZERO;
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                        tx_nxt_s    = 1'b1;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                        shreg_nxt_s   = {1'b0, shreg_r[7:1]};
                        tx_nxt_s      = shreg_r[1];
                    end
                end else begin
                    baud_nxt_s = baud_r + BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    baud_nxt_s = BAUD_ZERO;
                    // RTS is only sampled here and in IDLE, so a frame in flight always completes.
                    if (start_ok_s) begin
                        pop_s       = 1'b1;
                        shreg_nxt_s = head_s;
                        state_nxt_s = ST_START;
                        tx_nxt_s    = 1'b0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        tx_nxt_s    = 1'b1;
                        busy_nxt_s  = 1'b0;
                    end
                end else begin
                    baud_nxt_s = baud_r + BAUD_ONE;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                baud_nxt_s    = BAUD_ZERO;
                bit_idx_nxt_s = 3'd0;
                tx_nxt_s      = 1'b1;
                busy_nxt_s    = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered line/busy outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            baud_r    <= BAUD_ZERO;
            bit_idx_r <= 3'd0;
            shreg_r   <= 8'h00;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            baud_r    <= baud_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shreg_r   <= shreg_nxt_s;
            tx_r      <= tx_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    assign UART_Tx    = tx_r;
    assign busy       = busy_r;
    assign data_ready = ready_r;
    assign fifo_empty = empty_r;
    assign fifo_full  = full_r;

endmodule
